// File: rtl/seq_restoring_divider.sv
// Sequential unsigned restoring divider, one quotient bit per clock.
// Trial subtraction is an add of the inverted divisor with carry-in 1.
module seq_restoring_divider #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        FINISH
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] q_q;
    logic [WIDTH-1:0] r_q;
    logic [WIDTH-1:0] d_q;
    logic [CW-1:0]    count;

    logic [WIDTH:0]   r_sh;
    logic [WIDTH:0]   trial;
    logic             carry;
    logic [WIDTH-1:0] q_next;
    logic [WIDTH-1:0] r_next;
    logic             last;
    logic             accept;

    // One shift-and-subtract step. r_sh < 2*divisor, so the signed
    // difference fits in WIDTH+1 bits and the add's carry-out is the
    // complement of the difference's top bit.
    always_comb begin
        r_sh   = {r_q, q_q[WIDTH-1]};
        trial  = r_sh + ~{1'b0, d_q} + (WIDTH+1)'(1);
        carry  = ~trial[WIDTH];
        q_next = {q_q[WIDTH-2:0], carry};
        r_next = carry ? trial[WIDTH-1:0] : r_sh[WIDTH-1:0];
        last   = (count == CW'(WIDTH - 1));
        accept = start && (state != RUN);
    end

    // Control FSM and registered datapath/outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            q_q         <= '0;
            r_q         <= '0;
            d_q         <= '0;
            count       <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
        end else begin
            unique case (state)
                IDLE, FINISH: begin
                    done <= 1'b0;
                    if (state == FINISH) begin
                        state <= IDLE;
                    end
                    if (accept) begin
                        d_q         <= divisor;
                        q_q         <= dividend;
                        r_q         <= '0;
                        count       <= '0;
                        div_by_zero <= 1'b0;
                        if (divisor == '0) begin
                            state       <= FINISH;
                            busy        <= 1'b0;
                            done        <= 1'b1;
                            div_by_zero <= 1'b1;
                            quotient    <= '1;
                            remainder   <= dividend;
                        end else begin
                            state <= RUN;
                            busy  <= 1'b1;
                        end
                    end
                end
                RUN: begin
                    q_q   <= q_next;
                    r_q   <= r_next;
                    count <= count + CW'(1);
                    if (last) begin
                        state     <= FINISH;
                        busy      <= 1'b0;
                        done      <= 1'b1;
                        quotient  <= q_next;
                        remainder <= r_next;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_seq_restoring_divider.sv
// Directed and randomized checks for seq_restoring_divider.
// Cycle index k below means "the cycle after accepting edge E0 + k".
module tb_seq_restoring_divider;

    logic        clk;
    logic        rst;
    logic        start;
    logic [15:0] dividend;
    logic [15:0] divisor;
    logic        busy;
    logic        done;
    logic [15:0] quotient;
    logic [15:0] remainder;
    logic        div_by_zero;

    int tests;
    int fails;
    logic prev_done;

    seq_restoring_divider #(.WIDTH(16)) dut (
        .clk(clk),
        .rst(rst),
        .start(start),
        .dividend(dividend),
        .divisor(divisor),
        .busy(busy),
        .done(done),
        .quotient(quotient),
        .remainder(remainder),
        .div_by_zero(div_by_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // busy/done exclusivity and single-cycle done pulse
    always @(negedge clk) begin
        if (rst) begin
            prev_done = 1'b0;
        end else begin
            if (busy || done) begin
                tests++;
                if (busy && done) begin
                    fails++;
                    $display("FAIL busy_done_excl got busy=%b done=%b want not both", busy, done);
                end
            end
            if (done) begin
                tests++;
                if (prev_done) begin
                    fails++;
                    $display("FAIL done_width got done high 2 cycles want 1");
                end
            end
            prev_done = done;
        end
    end

    task automatic do_op(input logic [15:0] a, input logic [15:0] b,
                         output int lat, output int bcnt);
        @(negedge clk);
        dividend = a;
        divisor  = b;
        start    = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        lat  = -1;
        bcnt = 0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (done) begin
                lat = k;
                break;
            end
            if (busy) bcnt++;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        start = 1'b0;
        dividend = '0;
        divisor = '0;
        #3;
        tests++;
        if ({busy, done, div_by_zero} !== 3'b000) begin
            fails++;
            $display("FAIL reset_flags got %b want 000", {busy, done, div_by_zero});
        end
        tests++;
        if ({quotient, remainder} !== 32'd0) begin
            fails++;
            $display("FAIL reset_results got q=%h r=%h want 0 0", quotient, remainder);
        end
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_basic();
        int lat, bc;
        do_op(16'd100, 16'd7, lat, bc);
        tests++;
        if (lat !== 16) begin
            fails++;
            $display("FAIL basic_latency got %0d want 16", lat);
        end
        tests++;
        if (bc !== 16) begin
            fails++;
            $display("FAIL basic_busy_cycles got %0d want 16", bc);
        end
        tests++;
        if (quotient !== 16'd14 || remainder !== 16'd2 || div_by_zero !== 1'b0) begin
            fails++;
            $display("FAIL basic_result got q=%0d r=%0d z=%b want 14 2 0",
                     quotient, remainder, div_by_zero);
        end
        @(negedge clk);
        tests++;
        if (done !== 1'b0 || quotient !== 16'd14 || remainder !== 16'd2) begin
            fails++;
            $display("FAIL basic_after_done got done=%b q=%0d r=%0d want 0 14 2",
                     done, quotient, remainder);
        end
    endtask

    task automatic test_boundaries();
        logic [15:0] va [3] = '{16'hFFFF, 16'hFFFF, 16'd5};
        logic [15:0] vb [3] = '{16'h0001, 16'hFFFF, 16'd9};
        logic [15:0] eq [3] = '{16'hFFFF, 16'h0001, 16'd0};
        logic [15:0] er [3] = '{16'h0000, 16'h0000, 16'd5};
        int lat, bc;
        for (int i = 0; i < 3; i++) begin
            do_op(va[i], vb[i], lat, bc);
            tests++;
            if (lat !== 16 || quotient !== eq[i] || remainder !== er[i]
                || div_by_zero !== 1'b0) begin
                fails++;
                $display("FAIL boundary_%0d got lat=%0d q=%h r=%h z=%b want 16 %h %h 0",
                         i, lat, quotient, remainder, div_by_zero, eq[i], er[i]);
            end
        end
    endtask

    task automatic test_div_zero();
        int lat, bc;
        do_op(16'd1234, 16'd0, lat, bc);
        tests++;
        if (lat !== 0) begin
            fails++;
            $display("FAIL dz_latency got cycle %0d want 0", lat);
        end
        tests++;
        if (bc !== 0 || busy !== 1'b0) begin
            fails++;
            $display("FAIL dz_busy got %0d busy cycles want 0", bc);
        end
        tests++;
        if (quotient !== 16'hFFFF || remainder !== 16'd1234 || div_by_zero !== 1'b1) begin
            fails++;
            $display("FAIL dz_result got q=%h r=%0d z=%b want ffff 1234 1",
                     quotient, remainder, div_by_zero);
        end
    endtask

    task automatic test_back_to_back();
        int lat;
        @(negedge clk);
        dividend = 16'd200;
        divisor  = 16'd3;
        start    = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        lat = -1;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (done) begin
                lat = k;
                break;
            end
            if (k == 2) begin
                start = 1'b1;
                dividend = 16'd9;
                divisor = 16'd2;
            end
            if (k == 3) start = 1'b0;
            if (k == 5) begin
                dividend = 16'd77;
                divisor = 16'd5;
            end
        end
        tests++;
        if (lat !== 16 || quotient !== 16'd66 || remainder !== 16'd2) begin
            fails++;
            $display("FAIL ignore_start got lat=%0d q=%0d r=%0d want 16 66 2",
                     lat, quotient, remainder);
        end
        dividend = 16'd9;
        divisor  = 16'd2;
        start    = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        tests++;
        if (busy !== 1'b1 || done !== 1'b0) begin
            fails++;
            $display("FAIL b2b_accept got busy=%b done=%b want 1 0", busy, done);
        end
        lat = -1;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (done) begin
                lat = k;
                break;
            end
        end
        tests++;
        if (lat !== 16 || quotient !== 16'd4 || remainder !== 16'd1
            || div_by_zero !== 1'b0) begin
            fails++;
            $display("FAIL b2b_result got lat=%0d q=%0d r=%0d z=%b want 16 4 1 0",
                     lat, quotient, remainder, div_by_zero);
        end
    endtask

    task automatic test_reset_mid_run();
        int lat, bc, seen;
        @(negedge clk);
        dividend = 16'd40000;
        divisor  = 16'd3;
        start    = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (8) @(posedge clk);
        #3 rst = 1'b1;
        #1;
        tests++;
        if ({busy, done, div_by_zero} !== 3'b000 || {quotient, remainder} !== 32'd0) begin
            fails++;
            $display("FAIL async_reset got busy=%b done=%b z=%b q=%h r=%h want all 0",
                     busy, done, div_by_zero, quotient, remainder);
        end
        seen = 0;
        repeat (3) begin
            @(negedge clk);
            if (done || busy) seen++;
        end
        rst = 1'b0;
        repeat (20) begin
            @(negedge clk);
            if (done || busy) seen++;
        end
        tests++;
        if (seen !== 0) begin
            fails++;
            $display("FAIL reset_no_done got %0d active cycles want 0", seen);
        end
        do_op(16'd50000, 16'd123, lat, bc);
        tests++;
        if (lat !== 16 || quotient !== 16'd406 || remainder !== 16'd62) begin
            fails++;
            $display("FAIL post_reset got lat=%0d q=%0d r=%0d want 16 406 62",
                     lat, quotient, remainder);
        end
    endtask

    task automatic test_random();
        logic [15:0] a, b;
        int lat, bc, sel;
        bit ok;
        for (int i = 0; i < 1500; i++) begin
            a = 16'($urandom);
            sel = $urandom_range(0, 7);
            if (sel == 0) b = 16'd0;
            else if (sel == 1) b = 16'd1;
            else if (sel == 2) b = 16'($urandom_range(2, 255));
            else b = 16'($urandom);
            do_op(a, b, lat, bc);
            if (b == 16'd0) begin
                ok = (lat == 0) && (quotient == 16'hFFFF)
                     && (remainder == a) && div_by_zero;
            end else begin
                ok = (lat == 16) && !div_by_zero && (remainder < b)
                     && (32'(quotient) * 32'(b) + 32'(remainder) == 32'(a));
            end
            tests++;
            if (!ok) begin
                fails++;
                $display("FAIL random_%0d got a=%0d b=%0d q=%0d r=%0d z=%b lat=%0d want a=q*b+r r<b",
                         i, a, b, quotient, remainder, div_by_zero, lat);
            end
        end
    endtask

    initial begin
        tests = 0;
        fails = 0;
        prev_done = 1'b0;
        test_reset();
        test_basic();
        test_boundaries();
        test_div_zero();
        test_back_to_back();
        test_reset_mid_run();
        test_random();
        repeat (2) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
